// File: rtl/func2_if.sv
// Signal bundle for one func2 instance: function inputs plus the
// combinational and registered status outputs.
interface func2_if #(
   parameter int unsigned CNT_W = 8
);
   logic             a;
   logic             b;
   logic             c;
   logic             d;
   logic             out;
   logic             out_q;
   logic             out_rise;
   logic [CNT_W-1:0] hi_count;

   // Stimulus side drives the function inputs and observes results.
   modport master (
      output a, b, c, d,
      input  out, out_q, out_rise, hi_count
   );

   // Function unit side.
   modport slave (
      input  a, b, c, d,
      output out, out_q, out_rise, hi_count
   );
endinterface

// File: rtl/func2.sv
// 4-input Boolean function F = sum m(0,1,2,5,8,9,10) with a registered
// side-path: registered copy, 0->1 edge pulse and saturating count of
// cycles where F was sampled high.
module func2 #(
   parameter int unsigned CNT_W = 8
) (
   output logic             out,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   input  logic             D,
   input  logic             clk,
   input  logic             rst_n,
   output logic             out_q,
   output logic             out_rise,
   output logic [CNT_W-1:0] hi_count
);

   localparam logic [CNT_W-1:0] CntMax = '1;
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   // Minimal SOP form B'D' + B'C' + A'C'D; X/Z on inputs propagates freely.
   always_comb begin
      out = (~B & ~D) | (~B & ~C) | (~A & ~C & D);
   end

   // Registered copy, rising-edge pulse and saturating high-cycle counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q    <= 1'b0;
         out_rise <= 1'b0;
         hi_count <= '0;
      end else begin
         out_q    <= out;
         out_rise <= out & ~out_q;
         if (out && (hi_count != CntMax)) begin
            hi_count <= hi_count + CntOne;
         end
      end
   end

endmodule

// File: tb/tb_func2.sv
// Scoreboard bench for func2: a driver pushes expected results computed
// from the minterm list, a monitor pops and compares after each clock edge.
module tb_func2;

   logic clk;
   logic rst_n;
   logic clk_en;

   func2_if #(.CNT_W(8)) bus8 ();
   func2_if #(.CNT_W(4)) bus4 ();

   func2 #(.CNT_W(8)) dut8 (
      .out      (bus8.out),
      .A        (bus8.a),
      .B        (bus8.b),
      .C        (bus8.c),
      .D        (bus8.d),
      .clk      (clk),
      .rst_n    (rst_n),
      .out_q    (bus8.out_q),
      .out_rise (bus8.out_rise),
      .hi_count (bus8.hi_count)
   );

   func2 #(.CNT_W(4)) dut4 (
      .out      (bus4.out),
      .A        (bus4.a),
      .B        (bus4.b),
      .C        (bus4.c),
      .D        (bus4.d),
      .clk      (clk),
      .rst_n    (rst_n),
      .out_q    (bus4.out_q),
      .out_rise (bus4.out_rise),
      .hi_count (bus4.hi_count)
   );

   typedef struct {
      logic       f;
      logic       q;
      logic       rise;
      logic [7:0] c8;
      logic [3:0] c4;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference state, kept as plain integers.
   logic m_q;
   logic m_rise;
   int   m_c8;
   int   m_c4;

   function automatic logic f_ref(input int idx);
      return (idx inside {0, 1, 2, 5, 8, 9, 10});
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [3:0] idx);
      {bus8.a, bus8.b, bus8.c, bus8.d} = idx;
      {bus4.a, bus4.b, bus4.c, bus4.d} = idx;
   endtask

   // One clocked transaction: drive, predict, push, then wait one cycle.
   task automatic step(input logic [3:0] idx, input logic rn);
      exp_t e;
      logic f;
      drive(idx);
      rst_n = rn;
      f = f_ref(int'(idx));
      if (!rn) begin
         m_q = 1'b0;
         m_rise = 1'b0;
         m_c8 = 0;
         m_c4 = 0;
      end else begin
         m_rise = f & ~m_q;
         m_q = f;
         if (f && m_c8 < 255) m_c8++;
         if (f && m_c4 < 15) m_c4++;
      end
      e.f = f;
      e.q = m_q;
      e.rise = m_rise;
      e.c8 = 8'(m_c8);
      e.c4 = 4'(m_c4);
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   // Clock only runs once the combinational sweep is done.
   initial begin
      clk = 1'b0;
      wait (clk_en);
      forever #5 clk = ~clk;
   end

   // Monitor: compare every registered output shortly after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("out8", 8'(bus8.out), 8'(e.f));
            chk("out4", 8'(bus4.out), 8'(e.f));
            chk("out_q8", 8'(bus8.out_q), 8'(e.q));
            chk("out_q4", 8'(bus4.out_q), 8'(e.q));
            chk("out_rise8", 8'(bus8.out_rise), 8'(e.rise));
            chk("out_rise4", 8'(bus4.out_rise), 8'(e.rise));
            chk("hi_count8", bus8.hi_count, e.c8);
            chk("hi_count4", 8'(bus4.hi_count), 8'(e.c4));
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   // Driver.
   initial begin
      clk_en = 1'b0;
      rst_n = 1'b0;
      m_q = 1'b0;
      m_rise = 1'b0;
      m_c8 = 0;
      m_c4 = 0;

      // Combinational sweep with no clock activity.
      for (int i = 0; i < 16; i++) begin
         drive(4'(i));
         #5;
         chk("sweep8", 8'(bus8.out), 8'(f_ref(i)));
         chk("sweep4", 8'(bus4.out), 8'(f_ref(i)));
         #5;
      end

      clk_en = 1'b1;
      // Reset for two edges, inputs 0000.
      drive(4'b0000);
      #1;
      chk("out_in_reset", 8'(bus8.out), 8'd1);
      step(4'b0000, 1'b0);
      step(4'b0000, 1'b0);
      // Release and hold 0000.
      for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
      chk("hi_count_after3", bus8.hi_count, 8'd3);
      // Alternate F=0 / F=1.
      for (int i = 0; i < 8; i++) step((i % 2 == 0) ? 4'b0011 : 4'b0101, 1'b1);
      chk("hi_count_after_alt", bus8.hi_count, 8'd7);
      // Hold 1010 long enough to saturate the narrow counter.
      for (int i = 0; i < 20; i++) step(4'b1010, 1'b1);
      chk("sat4", 8'(bus4.hi_count), 8'd15);
      // Count to 7 then reset with F=1, then resume.
      step(4'b0000, 1'b0);
      for (int i = 0; i < 7; i++) step(4'b1000, 1'b1);
      chk("hi_count_pre_rst", bus8.hi_count, 8'd7);
      step(4'b1000, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b1001, 1'b1);
      // Randomized traffic with occasional resets.
      for (int i = 0; i < 300; i++) begin
         step(4'($urandom_range(15)), ($urandom_range(15) != 0));
      end
      // Long F=1 run to saturate the wide counter too.
      for (int i = 0; i < 270; i++) step(4'b0001, 1'b1);
      chk("sat8", bus8.hi_count, 8'd255);

      @(posedge clk);
      #2;
      chk("sb_drain", 8'(sb.size()), 8'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/func2.md
Name: func2

Overview:
- 4-input Boolean function unit implementing F(A,B,C,D) = Σm(0,1,2,5,8,9,10), equivalent to B'D' + B'C' + A'C'D.
- Primary output `out` is purely combinational, so exhaustive-stimulus benches can check it with no clock activity.
- A synchronous side-path provides a registered copy of F, a rising-edge pulse and a saturating count of cycles where F=1, for downstream status logic.

Parameters:
- CNT_W, 8, width of the high-cycle counter `hi_count`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- out  output  1  combinational F(A,B,C,D).
- A  input  1  function input, MSB of minterm index.
- B  input  1  function input.
- C  input  1  function input.
- D  input  1  function input, LSB of minterm index.
- out_q  output  1  F registered on clk.
- out_rise  output  1  one-cycle pulse when registered F goes 0->1.
- hi_count  output  CNT_W  saturating count of clocked cycles with F=1.
- Declaration order is fixed as out, A, B, C, D, clk, rst_n, out_q, out_rise, hi_count. Positional instantiation with the first five ports must remain valid.

Behaviour:
- Minterm index is {A,B,C,D} (A=bit3, D=bit0).
- `out` is 1 for indices 0,1,2,5,8,9,10 and 0 for indices 3,4,6,7,11,12,13,14,15.
- `out` has zero latency and no dependence on clk or rst_n; it is valid even while reset is held.
- X/Z on any input may propagate to `out`; no masking is performed.
- Reset: on a rising clk edge with rst_n=0, out_q<=0, out_rise<=0, hi_count<=0. Reset takes priority over all other updates.
- Normal operation, each rising clk edge with rst_n=1:
  - out_q <= F of current inputs (1-cycle latency).
  - out_rise <= F & ~out_q. It pulses exactly one cycle per 0->1 transition of the sampled F, and is 0 on the first post-reset cycle unless F=1 then.
  - hi_count <= hi_count + 1 when F=1 and hi_count < 2^CNT_W-1. It holds at 2^CNT_W-1 (saturates, never wraps) and holds when F=0.
- Reset asserted mid-count clears hi_count on that edge regardless of F.
- Input changes between clock edges affect only `out`; registered outputs see only the value at the edge.
- No handshake, no state machine beyond the registers above.

Test Plan:
- Exhaustive sweep of {A,B,C,D} = 0..15, 10 time units each, no clock: out = 1,1,1,0,0,1,0,0,1,1,1,0,0,0,0,0.
- rst_n=0 for 2 clk edges with inputs=0000: out=1 immediately; out_q=0, out_rise=0, hi_count=0.
- Release reset, hold 0000 for 3 clocks: out_q=1 after the first edge, out_rise=1 for that single cycle then 0, hi_count=3.
- Alternate 0011 (F=0) and 0101 (F=1) each clock for 8 clocks: out_rise pulses on every cycle after a 0101 sample, and hi_count increments by 4.
- CNT_W=4, hold 1010 for 20 clocks: hi_count saturates at 15 and stays 15.
- Assert rst_n=0 for one edge while hi_count=7 and F=1: hi_count=0, out_q=0, out_rise=0 on that edge; counting resumes after release.
